// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding and default operand width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub_1bit.sv
// Combinational 1-bit full subtractor built from two half subtractors plus an OR.
module full_sub_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    logic d1;
    logic b1;
    logic b2;

    half_sub u_hs0 (
        .i_a  (i_a),
        .i_b  (i_b),
        .o_d  (d1),
        .o_bo (b1)
    );

    half_sub u_hs1 (
        .i_a  (d1),
        .i_b  (i_bin),
        .o_d  (o_diff),
        .o_bo (b2)
    );

    assign o_bout = b1 | b2;

endmodule

// File: rtl/half_sub.sv
// Combinational half subtractor: d = a - b with borrow out.
module half_sub (
    input  logic i_a,
    input  logic i_b,
    output logic o_d,
    output logic o_bo
);

    assign o_d  = i_a ^ i_b;
    assign o_bo = ~i_a & i_b;

endmodule

// File: rtl/serial_sub_nbit.sv
// Bit-serial WIDTH-bit subtractor (A - B), LSB first, one registered borrow.
// Optional signed overflow output enabled by macro SERIAL_SUB_OVERFLOW_EN.
module serial_sub_nbit
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cell_diff;
    logic             cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    full_sub_1bit u_cell (
        .i_a    (a_q[0]),
        .i_b    (b_q[0]),
        .i_bin  (borrow_q),
        .o_diff (cell_diff),
        .o_bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = SHIFT;
                    a_d      = i_a;
                    b_d      = i_b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d  = i_a[WIDTH-1];
                    b_msb_d  = i_b[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                diff_d   = {cell_diff, diff_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                // Counter holds at LAST so it never wraps, even for power-of-two widths.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_diff);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_diff   = diff_q;
    assign o_borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign o_ovf    = ovf_q;
`endif

endmodule
